// File: rtl/rr_mux_arb.sv
// rr_mux_arb: N-channel, W-bit registered multiplexer with a built-in arbiter.
// Chooses among requesting input channels (round-robin or fixed priority)
// and holds the winner in a one-entry output register with valid/ready.
//
// Ports:
//   clk       - clock, all state updates on the rising edge
//   rst       - synchronous active-high reset
//   in_valid  - per-channel request (bit i = channel i)
//   in_data   - packed channel data, channel i at [i*W +: W]
//   in_ready  - per-channel accept, at most one bit high (combinational)
//   out_valid - output register holds a word
//   out_data  - registered data word
//   out_sel   - index of the channel that sourced out_data
//   out_ready - consumer accepts the word
module rr_mux_arb #(
  parameter int N    = 4,
  parameter int W    = 8,
  parameter int MODE = 0,
  parameter int SW   = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   in_valid,
  input  logic [N*W-1:0] in_data,
  output logic [N-1:0]   in_ready,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_sel,
  input  logic           out_ready
);

  logic [SW-1:0] ptr;
  logic [SW-1:0] grant;
  logic [SW-1:0] low_any;
  logic [SW-1:0] low_hi;
  logic          hit_any;
  logic          hit_hi;
  logic          load_ok;
  logic          fire;
  logic [W-1:0]  chan [N];

  // Round-robin search is split into two scans: the lowest requester at or
  // above ptr, and the lowest requester overall (used when the first scan
  // finds nothing, i.e. the search wraps past N-1 back to 0).
  always_comb begin
    low_any = '0;
    low_hi  = '0;
    hit_any = 1'b0;
    hit_hi  = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (in_valid[i] && !hit_any) begin
        hit_any = 1'b1;
        low_any = SW'(i);
      end
      if (in_valid[i] && !hit_hi && (SW'(i) >= ptr)) begin
        hit_hi = 1'b1;
        low_hi = SW'(i);
      end
    end
    if (MODE == 0 && hit_hi) begin
      grant = low_hi;
    end else begin
      grant = low_any;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      chan[i] = in_data[i*W +: W];
    end
  end

  assign load_ok = !out_valid || out_ready;
  assign fire    = hit_any && load_ok && !rst;

  always_comb begin
    in_ready = '0;
    if (fire) begin
      in_ready[grant] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (fire) begin
      out_valid <= 1'b1;
      out_data  <= chan[grant];
      out_sel   <= grant;
      if (MODE == 0) begin
        ptr <= (grant == SW'(N - 1)) ? '0 : grant + 1'b1;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_mux_arb.sv
// tb_rr_mux_arb: directed self-checking bench for rr_mux_arb.
// Three instances: N=4 round-robin, N=4 fixed priority, N=3 round-robin.
module tb_rr_mux_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // instance 0: N=4, MODE 0
  logic        rst0, ordy0, ov0;
  logic [3:0]  iv0, ir0;
  logic [31:0] id0;
  logic [7:0]  od0;
  logic [1:0]  os0;

  // instance 1: N=4, MODE 1
  logic        rst1, ordy1, ov1;
  logic [3:0]  iv1, ir1;
  logic [31:0] id1;
  logic [7:0]  od1;
  logic [1:0]  os1;

  // instance 2: N=3, MODE 0
  logic        rst2, ordy2, ov2;
  logic [2:0]  iv2, ir2;
  logic [23:0] id2;
  logic [7:0]  od2;
  logic [1:0]  os2;

  rr_mux_arb #(.N(4), .W(8), .MODE(0)) u0 (
    .clk(clk), .rst(rst0), .in_valid(iv0), .in_data(id0), .in_ready(ir0),
    .out_valid(ov0), .out_data(od0), .out_sel(os0), .out_ready(ordy0)
  );

  rr_mux_arb #(.N(4), .W(8), .MODE(1)) u1 (
    .clk(clk), .rst(rst1), .in_valid(iv1), .in_data(id1), .in_ready(ir1),
    .out_valid(ov1), .out_data(od1), .out_sel(os1), .out_ready(ordy1)
  );

  rr_mux_arb #(.N(3), .W(8), .MODE(0)) u2 (
    .clk(clk), .rst(rst2), .in_valid(iv2), .in_data(id2), .in_ready(ir2),
    .out_valid(ov2), .out_data(od2), .out_sel(os2), .out_ready(ordy2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst0 = 1'b1; iv0 = 4'b1111; id0 = 32'hA3A2A1A0; ordy0 = 1'b1;
    rst1 = 1'b1; iv1 = 4'b0000; id1 = 32'hA3A2A1A0; ordy1 = 1'b1;
    rst2 = 1'b1; iv2 = 3'b000;  id2 = 24'hB2B1B0;   ordy2 = 1'b1;
    #1;

    // 1. reset with all channels requesting
    chk("rst_ready_pre", 32'(ir0), 32'h0);
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("rst_valid", 32'(ov0), 32'h0);
      chk("rst_data", 32'(od0), 32'h00);
      chk("rst_sel", 32'(os0), 32'h0);
      chk("rst_ready", 32'(ir0), 32'h0);
    end
    rst0 = 1'b0;
    #1;

    // 2. round-robin rotation 0,1,2,3,0
    for (int k = 0; k < 5; k++) begin
      chk("rr_ready", 32'(ir0), 32'(4'b0001 << (k % 4)));
      tick();
      chk("rr_valid", 32'(ov0), 32'h1);
      chk("rr_sel", 32'(os0), 32'(k % 4));
      chk("rr_data", 32'(od0), 32'(8'hA0 + (k % 4)));
    end

    // 3. sparse requests 1,3,1,3 then wrap to 0
    rst0 = 1'b1;
    tick();
    rst0 = 1'b0;
    iv0 = 4'b1010;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("sparse_ready", 32'(ir0), (k % 2 == 0) ? 32'h2 : 32'h8);
      tick();
      chk("sparse_sel", 32'(os0), (k % 2 == 0) ? 32'h1 : 32'h3);
    end
    iv0 = 4'b1011;
    #1;
    chk("wrap_ready", 32'(ir0), 32'h1);
    tick();
    chk("wrap_sel", 32'(os0), 32'h0);
    chk("wrap_data", 32'(od0), 32'hA0);
    iv0 = 4'b0001;
    tick();
    chk("only0_sel", 32'(os0), 32'h0);

    // 4. fixed priority on instance 1
    rst1 = 1'b0;
    iv1 = 4'b1110;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("fp_ready", 32'(ir1), 32'h2);
      tick();
      chk("fp_sel", 32'(os1), 32'h1);
      chk("fp_data", 32'(od1), 32'hA1);
    end
    iv1 = 4'b1100;
    tick();
    chk("fp_drop_sel", 32'(os1), 32'h2);
    chk("fp_drop_data", 32'(od1), 32'hA2);

    // 5. backpressure on instance 0
    rst0 = 1'b1;
    tick();
    rst0 = 1'b0;
    id0 = 32'hA35CA1A0;
    iv0 = 4'b0100;
    tick();
    chk("bp_load_sel", 32'(os0), 32'h2);
    chk("bp_load_data", 32'(od0), 32'h5C);
    ordy0 = 1'b0;
    iv0 = 4'b1011;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_ready", 32'(ir0), 32'h0);
      tick();
      chk("bp_valid", 32'(ov0), 32'h1);
      chk("bp_data", 32'(od0), 32'h5C);
      chk("bp_sel", 32'(os0), 32'h2);
    end
    ordy0 = 1'b1;
    #1;
    chk("bp_release_ready", 32'(ir0), 32'h8);
    tick();
    chk("bp_release_valid", 32'(ov0), 32'h1);
    chk("bp_release_sel", 32'(os0), 32'h3);
    chk("bp_release_data", 32'(od0), 32'hA3);
    iv0 = 4'b0000;
    tick();
    chk("drain_valid", 32'(ov0), 32'h0);
    chk("drain_data", 32'(od0), 32'hA3);
    chk("drain_sel", 32'(os0), 32'h3);

    // 6. N=3 rotation and reset mid-stall
    rst2 = 1'b0;
    iv2 = 3'b111;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("n3_ready", 32'(ir2), 32'(3'b001 << (k % 3)));
      tick();
      chk("n3_sel", 32'(os2), 32'(k % 3));
      chk("n3_data", 32'(od2), 32'(8'hB0 + (k % 3)));
    end
    ordy2 = 1'b0;
    #1;
    chk("n3_stall_ready", 32'(ir2), 32'h0);
    tick();
    chk("n3_stall_valid", 32'(ov2), 32'h1);
    rst2 = 1'b1;
    #1;
    chk("n3_rst_ready", 32'(ir2), 32'h0);
    tick();
    chk("n3_rst_valid", 32'(ov2), 32'h0);
    chk("n3_rst_data", 32'(od2), 32'h00);
    rst2 = 1'b0;
    ordy2 = 1'b1;
    #1;
    chk("n3_after_ready", 32'(ir2), 32'h1);
    tick();
    chk("n3_after_sel", 32'(os2), 32'h0);
    chk("n3_after_data", 32'(od2), 32'hB0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rr_mux_arb.md
# rr_mux_arb

Parametrised N-channel, W-bit registered multiplexer with per-channel valid/ready handshakes and a built-in arbiter. It replaces the combinational select-driven mux: instead of an external select, it chooses among requesting channels by round-robin or fixed priority and holds the result in a one-entry output register. It sits between multiple producer streams and a single consumer stream on the same clock domain.

## Interface

**Parameters**
- `N`, default 4: number of input channels. Must be ≥ 2. Need not be a power of two.
- `W`, default 8: data width per channel.
- `MODE`, default 0: arbitration mode. 0 selects round-robin; 1 selects fixed priority, with the lowest index winning.
- `SW`, default `$clog2(N)`: width of the channel index. Derived; do not override.

**Ports**
- `clk`, in, 1: the single clock. All state updates on its rising edge.
- `rst`, in, 1: reset. Synchronous and active-high.
- `in_valid`, in, N: per-channel request. Bit i belongs to channel i.
- `in_data`, in, N*W: channel i data is `in_data[i*W +: W]`.
- `in_ready`, out, N: per-channel accept. At most one bit is high.
- `out_valid`, out, 1: the output register holds a word.
- `out_data`, out, W: the registered data.
- `out_sel`, out, SW: index of the channel that sourced `out_data`.
- `out_ready`, in, 1: the consumer accepts the word.

## Operation

- **Load condition.** `load_ok = !out_valid || out_ready`. The output register may take a new word this cycle.
- **Grant selection.** `grant` is the winner among the set `in_valid` bits. It is valid only when at least one bit is set.
  - MODE 0: search starts at index `ptr`, ascends, and wraps from N-1 to 0. The first set bit wins.
  - MODE 1: the lowest set index wins. `ptr` is ignored.
- **Ready generation.** `in_ready` is combinational.
  - `in_ready[grant]` = `load_ok && |in_valid && !rst`.
  - All other bits are 0.
- **Input transfer.** Occurs on channel g when `in_valid[g] && in_ready[g]`. At the clock edge:
  - `out_data` ← channel g data.
  - `out_sel` ← g.
  - `out_valid` ← 1.
  - `ptr` ← (g+1 == N) ? 0 : g+1. This applies in MODE 0 only.
- **Drain.** If `out_valid && out_ready` and no input transfer occurs, then `out_valid` ← 0. `out_data` and `out_sel` keep their last values.
- **Simultaneous drain and load.** When `out_valid && out_ready` and an input transfer occur in the same cycle, the register is replaced. `out_valid` stays 1, giving one transfer per cycle.
- **Stall.** While `out_valid && !out_ready`:
  - `out_data` and `out_sel` are held stable.
  - All `in_ready` bits are 0.
  - `ptr` is unchanged.
- **Pointer advance.** `ptr` moves only on an input transfer, never on idle or stalled cycles. A requester that is not granted keeps its position relative to `ptr`.
- **Fairness (MODE 0).** With all N channels continuously valid and `out_ready` high, grants cycle 0,1,…,N-1,0,… and each channel is served once per N transfers.
- **Producer rule.** A producer holds `in_valid` and data until it sees `in_ready`. The block does not depend on this, because it samples data only on transfer.
- **Reset.** While `rst` is high, at the clock edge:
  - `out_valid` ← 0, `out_data` ← 0, `out_sel` ← 0, `ptr` ← 0.
  - `in_ready` is forced to 0 combinationally, so no transfer occurs during reset.
  - Reset mid-stall discards the held word.

## Timing

- **Latency.** 1 cycle from input transfer to `out_valid`/`out_data` at the output.
- **Throughput.** 1 word per cycle while `out_ready` is held high and any `in_valid` bit is set.
- **Combinational paths.** `in_ready` depends combinationally on `in_valid`, `out_ready`, `out_valid`, `ptr` and `rst`. There is no combinational path from `in_data` to any output.
- **Bubble behaviour.** When `out_ready` drops, the current word is held with no bubble. On re-assertion, it is consumed and a new word is loaded in the same cycle.
- **Non-power-of-two N.** `ptr` wraps at N-1 → 0. Index values ≥ N never occur on `ptr` or `out_sel`.

## Test plan

All scenarios use N=4 and W=8 unless stated otherwise.

1. **Reset.** Hold `rst`=1 for 2 cycles with `in_valid`=4'b1111 → `out_valid`=0, `out_data`=8'h00, `out_sel`=0 and `in_ready`=4'b0000 throughout reset. After release, the first grant is channel 0.
2. **Round-robin rotation.** MODE 0, `in_valid`=4'b1111, data = 8'hA0/A1/A2/A3, `out_ready`=1 → `out_sel` sequence 0,1,2,3,0,… on consecutive cycles and `out_data` A0,A1,A2,A3. Each word appears 1 cycle after its `in_ready`.
3. **Sparse requests and pointer wrap.** MODE 0, only channels 1 and 3 valid, starting with `ptr`=0 → grants 1,3,1,3. Then present only channel 0 after a grant to 3 → channel 0 is granted next, confirming wrap from 3 to 0.
4. **Fixed priority.** MODE 1, `in_valid`=4'b1110 held, `out_ready`=1 → `out_sel` stays 1 every cycle. Dropping bit 1 → `out_sel` becomes 2.
5. **Backpressure.** Load 8'h5C from channel 2, then hold `out_ready`=0 for 3 cycles with other channels valid → `out_data`=8'h5C, `out_sel`=2 and `out_valid`=1 are stable, with `in_ready`=0. On `out_ready`=1, the next word loads in the same cycle and `out_valid` stays 1.
6. **Non-power-of-two N and reset mid-stall.** With N=3, all valid → `out_sel` 0,1,2,0 and never 3. Asserting `rst` during a stall → `out_valid`=0 on the next cycle and the held word is not delivered.
